// File: rtl/pb_mode_ctrl.sv
// pb_mode_ctrl: classifies debounced push-button presses as short or long and
// steps a three-way mode selector (0 -> 1 -> 2 -> 0, long press returns to 0).
// Build option: define PB_MODE_CTRL_LONG_PRESS_EN to include the hold counter
// and LONG state. Without it, every press is a short press that strobes on the
// rise, and long_pulse is held at 0.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | button released, waiting for a rise
// PRESSED | button held, not yet classified as long
// LONG    | button held past LONG_CYC cycles, long strobe already issued
module pb_mode_ctrl #(
  parameter logic [7:0] LONG_CYC = 8'd200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pb_debounced,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic [1:0] mode,
  output logic       held
);

  // Reject hold thresholds the counter cannot represent meaningfully.
  if (LONG_CYC < 8'd2) begin : g_long_cyc_range
    $error("pb_mode_ctrl: LONG_CYC must be in 2..255");
  end

  logic       pb_d_q;
  logic       rise;
  logic       fall;
  logic       short_q, short_d;
  logic       long_q, long_d;
  logic       held_q, held_d;
  logic [1:0] mode_q, mode_d;

  // One-cycle delayed copy of the button level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pb_d_q <= 1'b0;
    end else begin
      pb_d_q <= pb_debounced;
    end
  end

  assign rise = pb_debounced & ~pb_d_q;
  assign fall = ~pb_debounced & pb_d_q;

`ifdef PB_MODE_CTRL_LONG_PRESS_EN

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cnt_inc;

  // Saturating increment: the counter parks at 8'hFF instead of wrapping.
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  // State and hold-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter update; a fall wins over reaching the threshold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESSED;
          cnt_d   = 8'd0;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_d = IDLE;
        end else if (pb_debounced) begin
          cnt_d = cnt_inc;
          if (cnt_inc == LONG_CYC - 8'd1) begin
            state_d = LONG;
          end
        end
      end
      LONG: begin
        if (fall) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Output decode from the transition being taken this cycle.
  always_comb begin
    short_d = (state_q == PRESSED) && (state_d == IDLE);
    long_d  = (state_q == PRESSED) && (state_d == LONG);
    held_d  = (state_d != IDLE);
  end

`else

  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } state_t;

  state_t state_q, state_d;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: enter PRESSED on rise, leave on fall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise) state_d = PRESSED;
      PRESSED: if (fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: without long-press detection the press is accepted on rise.
  always_comb begin
    short_d = (state_q == IDLE) && (state_d == PRESSED);
    long_d  = 1'b0;
    held_d  = (state_d != IDLE);
  end

`endif

  // Mode stepping from the registered strobes; an illegal 3 recovers to 0.
  always_comb begin
    mode_d = mode_q;
    if (mode_q == 2'd3) begin
      mode_d = 2'd0;
    end else if (long_q) begin
      mode_d = 2'd0;
    end else if (short_q) begin
      mode_d = (mode_q == 2'd2) ? 2'd0 : mode_q + 2'd1;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      short_q <= 1'b0;
      long_q  <= 1'b0;
      held_q  <= 1'b0;
      mode_q  <= 2'd0;
    end else begin
      short_q <= short_d;
      long_q  <= long_d;
      held_q  <= held_d;
      mode_q  <= mode_d;
    end
  end

  assign short_pulse = short_q;
  assign long_pulse  = long_q;
  assign held        = held_q;
  assign mode        = mode_q;

endmodule

// File: tb/tb_pb_mode_ctrl.sv
// Bench for pb_mode_ctrl: a behavioural press model predicts the output vector
// {short_pulse, long_pulse, mode, held} for every driven cycle; predictions are
// queued at drive time and popped when the DUT outputs are sampled.
module tb_pb_mode_ctrl;

  localparam logic [7:0] LC = 8'd10;

  logic       clk;
  logic       rst_n;
  logic       pb;
  logic       short_pulse;
  logic       long_pulse;
  logic       held;
  logic [1:0] mode;

  pb_mode_ctrl #(.LONG_CYC(LC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pb_debounced (pb),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .mode         (mode),
    .held         (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [4:0] exp_q[$];

  // press model state
  bit         m_prev;
  bit         m_active;
  bit         m_long_done;
  int         m_len;
  bit         m_short;
  bit         m_long;
  logic [1:0] m_mode;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev      = 1'b0;
    m_active    = 1'b0;
    m_long_done = 1'b0;
    m_len       = 0;
    m_short     = 1'b0;
    m_long      = 1'b0;
    m_mode      = 2'd0;
  endtask

  // Predict the outputs visible after the edge that samples level v.
  task automatic model_step(input bit v, output logic [4:0] e);
    bit         s;
    bit         l;
    logic [1:0] nm;
    s = 1'b0;
    l = 1'b0;
    if (m_short)     nm = (m_mode == 2'd2) ? 2'd0 : m_mode + 2'd1;
    else if (m_long) nm = 2'd0;
    else             nm = m_mode;
`ifdef PB_MODE_CTRL_LONG_PRESS_EN
    if (!m_active) begin
      if (v && !m_prev) begin
        m_active    = 1'b1;
        m_len       = 1;
        m_long_done = 1'b0;
      end
    end else if (!v) begin
      m_active = 1'b0;
      s        = !m_long_done;
    end else begin
      m_len++;
      if (!m_long_done && m_len == int'(LC)) begin
        m_long_done = 1'b1;
        l           = 1'b1;
      end
    end
`else
    if (!m_active) begin
      if (v && !m_prev) begin
        m_active = 1'b1;
        s        = 1'b1;
      end
    end else if (!v) begin
      m_active = 1'b0;
    end
`endif
    m_prev  = v;
    m_short = s;
    m_long  = l;
    m_mode  = nm;
    e = {s, l, nm, m_active};
  endtask

  // Drive one cycle from a falling edge; sample 1 ns after the rising edge.
  task automatic drive(input bit v, input string tag);
    logic [4:0] e;
    logic [4:0] o;
    pb = v;
    model_step(v, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o = {short_pulse, long_pulse, mode, held};
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      check_eq(tag, o, exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic press(input int n_hi, input int n_lo, input string tag);
    for (int i = 0; i < n_hi; i++) drive(1'b1, {tag, "_hi"});
    for (int i = 0; i < n_lo; i++) drive(1'b0, {tag, "_lo"});
  endtask

  // Asynchronous reset pulse in the middle of a cycle; pb_after is the level
  // the button has when reset is released.
  task automatic reset_mid(input bit pb_after, input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq({tag, "_async"}, {short_pulse, long_pulse, mode, held}, 5'd0);
    pb = pb_after;
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1;
    check_eq({tag, "_hold"}, {short_pulse, long_pulse, mode, held}, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    pb    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_state", {short_pulse, long_pulse, mode, held}, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (3) drive(1'b0, "idle");

    press(5, 4, "short5");
    check_eq("mode_after_short5", mode, 2'd1);
    press(3, 4, "short_to2");
    check_eq("mode_before_long", mode, 2'd2);
    press(30, 4, "hold30");
    check_eq("mode_after_hold30", mode, 2'd0);

    press(2, 3, "seq1");
    check_eq("seq_mode1", mode, 2'd1);
    press(2, 3, "seq2");
    check_eq("seq_mode2", mode, 2'd2);
    press(2, 3, "seq3");
    check_eq("seq_mode0", mode, 2'd0);

    press(9, 4, "rel_10th");
    press(10, 4, "long_edge");
    press(1, 3, "one_cyc");

    repeat (8) drive(1'b1, "pre_rst");
    reset_mid(1'b0, "rst_mid");
    repeat (5) drive(1'b0, "post_rst");

    press(2, 3, "bump_mode");
    repeat (4) drive(1'b1, "pre_rst2");
    reset_mid(1'b1, "rst_held");
    repeat (3) drive(1'b1, "resume_hi");
    repeat (4) drive(1'b0, "resume_lo");

    press(300, 4, "hold300");
    press(2, 2, "final");

    check_eq("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pb_mode_ctrl.md
PB_MODE_CTRL -- requirements
Module: pb_mode_ctrl

Interface
REQ-001 SHALL have parameter LONG_CYC, default 8'd200: cycles held that make a press long (range 2..255).
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port pb_debounced, input, 1 bit: debounced push-button level from the upstream debouncer; 1 = pressed.
REQ-005 SHALL have port short_pulse, output, 1 bit: one-cycle strobe per accepted short press.
REQ-006 SHALL have port long_pulse, output, 1 bit: one-cycle strobe per accepted long press.
REQ-007 SHALL have port mode, output, 2 bits: current mode index, legal values 0..2.
REQ-008 SHALL have port held, output, 1 bit: 1 while the FSM is in PRESSED or LONG.

Function
REQ-009 SHALL register pb_debounced once (pb_d) and use pb_debounced & ~pb_d as rise and ~pb_debounced & pb_d as fall.
REQ-010 SHALL implement FSM states IDLE, PRESSED, LONG, with all outputs registered.
REQ-011 SHALL move IDLE->PRESSED on rise and clear the 8-bit hold counter to 0 in that cycle.
REQ-012 SHALL increment the hold counter by 1 each cycle in PRESSED while pb_debounced=1, saturating at 8'hFF and never wrapping.
REQ-013 SHALL move PRESSED->LONG in the cycle the counter reaches LONG_CYC-1, asserting long_pulse on the next cycle.
REQ-014 SHALL move PRESSED->IDLE on fall, asserting short_pulse on the next cycle.
REQ-015 SHALL move LONG->IDLE on fall without asserting any pulse.
REQ-016 SHALL never assert short_pulse and long_pulse in the same cycle, and SHALL produce at most one pulse per press.
REQ-017 SHALL advance mode on short_pulse as 0->1->2->0, and SHALL force mode to 0 on long_pulse.
REQ-018 SHALL return a mode value of 3, if ever reached, to 0 on the next clock.
REQ-019 SHALL treat a fall that coincides with the counter reaching LONG_CYC-1 as a short press.
REQ-020 SHALL ignore rise while in PRESSED or LONG.

Reset
REQ-021 SHALL, while rst_n=0, asynchronously force state=IDLE, counter=0, pb_d=0, short_pulse=0, long_pulse=0, mode=0, held=0.
REQ-022 SHALL, on reset mid-press, resume from IDLE after release; a level still high at release of reset gives pb_d=0 and is therefore taken as a new rise.

Configuration
REQ-023 SHALL compile long-press detection in when macro PB_MODE_CTRL_LONG_PRESS_EN is defined, with behaviour as in REQ-010..REQ-020.
REQ-024 SHALL, when PB_MODE_CTRL_LONG_PRESS_EN is undefined, omit the counter and LONG state and hold long_pulse at 0.
REQ-025 SHALL, when PB_MODE_CTRL_LONG_PRESS_EN is undefined, assert short_pulse the cycle after rise (not on fall) and advance mode on it.
REQ-026 SHALL keep held functional (PRESSED until fall) when PB_MODE_CTRL_LONG_PRESS_EN is undefined.

Verification
REQ-027 SHALL cover: macro on, press held 5 cycles then released -> exactly one short_pulse 1 cycle after fall, mode 0->1, long_pulse stays 0.
REQ-028 SHALL cover: macro on, LONG_CYC=10, press held 30 cycles with mode=2 -> long_pulse exactly once 10 cycles after rise, mode=0, no pulse at release.
REQ-029 SHALL cover: macro on, three short presses from mode 0 -> mode sequence 1, 2, 0.
REQ-030 SHALL cover: macro on, LONG_CYC=10, release on the 10th held cycle -> short_pulse only, mode advances.
REQ-031 SHALL cover: rst_n pulsed low mid-press at counter=7 -> all outputs 0 immediately and asynchronously, no pulse on the following release.
REQ-032 SHALL cover: macro off, press held 300 cycles -> short_pulse 1 cycle after rise only, long_pulse never asserted, counter absent from synthesis.
